// File: rtl/ibfly_iter_pkg.sv
// Shared bit-manipulation definitions: operation codes, widths, engine states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ibfly_iter_pkg;

  localparam int BMU_W    = 32;
  localparam int BMU_NSTG = 5;

  typedef enum logic {
    BMU_PEXT = 1'b0,
    BMU_PDEP = 1'b1
  } bmu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ibfly_state_e;

  typedef logic [15:0] ibfly_cfg_t;

endpackage

// File: rtl/ibfly_iter_if.sv
// Operand/result handshake bundle between the issue logic and the ibfly engine.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface ibfly_iter_if;
  import ibfly_iter_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  bmu_op_e                in_op;
  logic [BMU_W-1:0]       in_data;
  logic [BMU_W-1:0]       in_mask;
  ibfly_cfg_t             ibfly_cfg0;
  ibfly_cfg_t             ibfly_cfg1;
  ibfly_cfg_t             ibfly_cfg2;
  ibfly_cfg_t             ibfly_cfg3;
  ibfly_cfg_t             ibfly_cfg4;
  logic                   out_valid;
  logic                   out_ready;
  logic [BMU_W-1:0]       out_data;

  modport master (
    output in_valid, in_op, in_data, in_mask,
    output ibfly_cfg0, ibfly_cfg1, ibfly_cfg2, ibfly_cfg3, ibfly_cfg4,
    output out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_op, in_data, in_mask,
    input  ibfly_cfg0, ibfly_cfg1, ibfly_cfg2, ibfly_cfg3, ibfly_cfg4,
    input  out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/ibfly_iter_stage.sv
// One (inverse-)butterfly stage selected by stg_i: swaps pairs (i, i+2^stg) where cfg bit is set.
// Latency: purely combinational.
// Backpressure: none.
module ibfly_stage
  import ibfly_iter_pkg::*;
(
  input  logic [BMU_W-1:0] data_i,
  input  ibfly_cfg_t       cfg_i,
  input  logic [2:0]       stg_i,
  output logic [BMU_W-1:0] data_o
);

  logic [BMU_W-1:0] stg_res [BMU_NSTG];

  for (genvar s = 0; s < BMU_NSTG; s++) begin : g_stg
    localparam int D = 1 << s;
    logic [BMU_W-1:0] res;
    for (genvar i = 0; i < BMU_W; i++) begin : g_bit
      // Both members of a pair compute the same switch index (they differ only in bit s).
      localparam int J = ((i >> (s + 1)) << s) | (i & (D - 1));
      if (((i >> s) & 1) == 0) begin : g_lo
        assign res[i] = cfg_i[J] ? data_i[i + D] : data_i[i];
      end else begin : g_hi
        assign res[i] = cfg_i[J] ? data_i[i - D] : data_i[i];
      end
    end
    assign stg_res[s] = res;
  end

  // Pick the stage being applied; out-of-range stage codes pass data through.
  always_comb begin
    data_o = data_i;
    for (int s = 0; s < BMU_NSTG; s++) begin
      if (stg_i == 3'(s)) data_o = stg_res[s];
    end
  end

endmodule

// File: rtl/ibfly_iter.sv
// Iterative pext/pdep engine: one network stage per cycle over a captured operand and config.
// Latency: accept at edge T, stages at T+1..T+5, out_valid from T+5; 7-cycle issue interval.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE; flush wins.
module ibfly_iter
  import ibfly_iter_pkg::*;
#(
  parameter int WIDTH = BMU_W,
  parameter int NSTG  = BMU_NSTG
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  ibfly_iter_if.slave bus
);

  ibfly_state_e     state_q, state_d;
  logic [2:0]       stg_q, stg_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] stage_out;
  bmu_op_e          op_q, op_d;
  ibfly_cfg_t       cfg_q [NSTG];
  ibfly_cfg_t       cfg_d [NSTG];
  ibfly_cfg_t       cur_cfg;
  logic             last_stg;

  // Config word for the stage applied this cycle.
  always_comb begin
    cur_cfg = '0;
    for (int s = 0; s < NSTG; s++) begin
      if (stg_q == 3'(s)) cur_cfg = cfg_q[s];
    end
  end

  ibfly_stage u_stage (
    .data_i (work_q),
    .cfg_i  (cur_cfg),
    .stg_i  (stg_q),
    .data_o (stage_out)
  );

  // pext walks distances upward (inverse butterfly), pdep walks them downward (butterfly).
  assign last_stg = (op_q == BMU_PEXT) ? (stg_q == 3'(NSTG - 1)) : (stg_q == 3'd0);

  // Next-state and datapath update; flush overrides both handshakes.
  always_comb begin
    state_d = state_q;
    stg_d   = stg_q;
    work_d  = work_q;
    mask_d  = mask_q;
    op_d    = op_q;
    cfg_d   = cfg_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_d     = bus.in_op;
            mask_d   = bus.in_mask;
            cfg_d[0] = bus.ibfly_cfg0;
            cfg_d[1] = bus.ibfly_cfg1;
            cfg_d[2] = bus.ibfly_cfg2;
            cfg_d[3] = bus.ibfly_cfg3;
            cfg_d[4] = bus.ibfly_cfg4;
            // pext drops unselected bits up front so they cannot leak into the packed result.
            work_d   = (bus.in_op == BMU_PEXT) ? (bus.in_data & bus.in_mask) : bus.in_data;
            stg_d    = (bus.in_op == BMU_PEXT) ? 3'd0 : 3'(NSTG - 1);
            state_d  = RUN;
          end
        end
        RUN: begin
          work_d = stage_out;
          if (last_stg)                state_d = DONE;
          else if (op_q == BMU_PEXT)   stg_d   = stg_q + 3'd1;
          else                         stg_d   = stg_q - 3'd1;
        end
        DONE: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and captured-operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stg_q   <= '0;
      work_q  <= '0;
      mask_q  <= '0;
      op_q    <= BMU_PEXT;
      for (int s = 0; s < NSTG; s++) cfg_q[s] <= '0;
    end else begin
      state_q <= state_d;
      stg_q   <= stg_d;
      work_q  <= work_d;
      mask_q  <= mask_d;
      op_q    <= op_d;
      cfg_q   <= cfg_d;
    end
  end

  // Outputs decode registered state only; pdep clears the junk left in unselected positions.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = (state_q != DONE)   ? '0 :
                         (op_q == BMU_PEXT)  ? work_q : (work_q & mask_q);

endmodule

// File: tb/tb_ibfly_iter.sv
// Bench for ibfly_iter: directed vectors, handshake/flush/reset sequences, random pext/pdep.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low.
module tb_ibfly_iter;
  import ibfly_iter_pkg::*;

  typedef logic [4:0][15:0] cfgs_t;
  typedef struct {
    bmu_op_e     op;
    logic [31:0] data;
    logic [31:0] mask;
    cfgs_t       cfg;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_tests = 0;
  int   n_fail  = 0;

  ibfly_iter_if bus ();

  ibfly_iter #(.WIDTH(32), .NSTG(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] pext_ref(input logic [31:0] data, input logic [31:0] mask);
    logic [31:0] r = '0;
    int k = 0;
    for (int i = 0; i < 32; i++) if (mask[i]) begin r[k] = data[i]; k++; end
    return r;
  endfunction

  function automatic logic [31:0] pdep_ref(input logic [31:0] data, input logic [31:0] mask);
    logic [31:0] r = '0;
    int k = 0;
    for (int i = 0; i < 32; i++) if (mask[i]) begin r[i] = data[k]; k++; end
    return r;
  endfunction

  function automatic int ones(input logic [31:0] mask, input int base, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(mask[base + i]);
    return c;
  endfunction

  function automatic bit in_rng(input int x, input int start, input int len, input int size);
    return ((((x - start) % size) + size) % size) < len;
  endfunction

  // Mask decoder: each 2d block gathers its selected bits into a cyclic run starting at
  // rotation r; the low half gets rotation r, the high half r+k (k = low-half popcount).
  function automatic cfgs_t decode(input logic [31:0] mask);
    cfgs_t c;
    int rot [32];
    int nrot [32];
    int d, base, k, m, r;
    c = '0;
    for (int i = 0; i < 32; i++) begin rot[i] = 0; nrot[i] = 0; end
    for (int s = 4; s >= 0; s--) begin
      d = 1 << s;
      for (int b = 0; b < 16 / d; b++) begin
        base = b * 2 * d;
        k = ones(mask, base, d);
        m = ones(mask, base + d, d);
        r = rot[b];
        for (int cc = 0; cc < d; cc++)
          c[s][b * d + cc] = in_rng(cc, r + k, m, 2 * d) || in_rng(cc + d, r, k, 2 * d);
        nrot[2 * b]     = r % d;
        nrot[2 * b + 1] = (r + k) % d;
      end
      rot = nrot;
    end
    return c;
  endfunction

  function automatic cfgs_t cfg_one(input int s, input logic [15:0] v);
    cfgs_t c = '0;
    c[s] = v;
    return c;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_in(input bmu_op_e op, input logic [31:0] data, input logic [31:0] mask,
                          input cfgs_t c);
    bus.in_op      = op;
    bus.in_data    = data;
    bus.in_mask    = mask;
    bus.ibfly_cfg0 = c[0];
    bus.ibfly_cfg1 = c[1];
    bus.ibfly_cfg2 = c[2];
    bus.ibfly_cfg3 = c[3];
    bus.ibfly_cfg4 = c[4];
  endtask

  // Presents one operand in IDLE, returns #1 after the accepting edge, then scrambles inputs.
  task automatic start_op(input bmu_op_e op, input logic [31:0] data, input logic [31:0] mask,
                          input cfgs_t c);
    logic [95:0] junk;
    drive_in(op, data, mask, c);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    junk = {$urandom, $urandom, $urandom};
    drive_in(($urandom_range(1) == 1) ? BMU_PDEP : BMU_PEXT, $urandom, $urandom, junk[79:0]);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input bmu_op_e op, input logic [31:0] data, input logic [31:0] mask,
                        input cfgs_t c, output logic [31:0] res, output int lat);
    start_op(op, data, mask, c);
    wait_valid(lat);
    res = bus.out_data;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [8];
    logic [31:0] res, data, mask, exp;
    int          lat;
    bmu_op_e     op;

    vecs[0] = '{BMU_PDEP, 32'hDEAD_BEEF, 32'hFFFF_FFFF, '0,                    32'hDEAD_BEEF};
    vecs[1] = '{BMU_PDEP, 32'h0000_0001, 32'hFFFF_FFFF, cfg_one(0, 16'hFFFF),  32'h0000_0002};
    vecs[2] = '{BMU_PDEP, 32'h0000_0001, 32'hFFFF_FFFF, cfg_one(4, 16'h0001),  32'h0001_0000};
    vecs[3] = '{BMU_PEXT, 32'hFFFF_FFFF, 32'h0000_00F0, decode(32'h0000_00F0), 32'h0000_000F};
    vecs[4] = '{BMU_PDEP, 32'h0000_000F, 32'h0000_00F0, decode(32'h0000_00F0), 32'h0000_00F0};
    vecs[5] = '{BMU_PEXT, 32'h0000_0001, 32'hFFFF_FFFF, cfg_one(1, 16'h0001),  32'h0000_0004};
    vecs[6] = '{BMU_PEXT, 32'hFFFF_FFFF, 32'h8000_0001, decode(32'h8000_0001), 32'h0000_0003};
    vecs[7] = '{BMU_PDEP, 32'h0000_0002, 32'h8000_0001, decode(32'h8000_0001), 32'h8000_0000};

    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive_in(BMU_PEXT, '0, '0, '0);
    #3;
    check("reset_state", {bus.in_ready, bus.out_valid, bus.out_data}, {1'b1, 1'b0, 32'h0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    for (int v = 0; v < 8; v++) begin
      run_op(vecs[v].op, vecs[v].data, vecs[v].mask, vecs[v].cfg, res, lat);
      check($sformatf("vec%0d_data", v), res, vecs[v].exp);
      check($sformatf("vec%0d_lat", v), lat, 5);
      check($sformatf("vec%0d_idle", v), {bus.in_ready, bus.out_valid}, 2'b10);
    end

    // Backpressure: result held for 20 cycles, accepted when out_ready rises.
    bus.out_ready = 1'b0;
    start_op(BMU_PEXT, 32'hFFFF_FFFF, 32'h0000_00F0, decode(32'h0000_00F0));
    wait_valid(lat);
    check("bp_lat", lat, 5);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("bp_hold%0d", k), {bus.in_ready, bus.out_valid, bus.out_data},
            {1'b0, 1'b1, 32'h0000_000F});
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    check("bp_release", {bus.out_valid, bus.out_data}, {1'b1, 32'h0000_000F});
    @(posedge clk); #1;
    check("bp_idle", {bus.in_ready, bus.out_valid}, 2'b10);

    // Flush while the stage-2 step is in progress.
    start_op(BMU_PDEP, 32'h0000_000F, 32'h0000_00F0, decode(32'h0000_00F0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_run_idle", {bus.in_ready, bus.out_valid}, 2'b10);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("flush_run_novld%0d", k), bus.out_valid, 1'b0);
      @(posedge clk); #1;
    end
    run_op(BMU_PDEP, 32'h0000_000F, 32'h0000_00F0, decode(32'h0000_00F0), res, lat);
    check("flush_next_op", {lat, res}, {32'd5, 32'h0000_00F0});

    // Flush while a result is waiting.
    bus.out_ready = 1'b0;
    start_op(BMU_PEXT, 32'hFFFF_FFFF, 32'h0000_00F0, decode(32'h0000_00F0));
    wait_valid(lat);
    check("flush_done_pre", {bus.out_valid, bus.out_data}, {1'b1, 32'h0000_000F});
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    check("flush_done_drop", {bus.in_ready, bus.out_valid}, 2'b10);

    // Flush coincident with in_valid in IDLE: operand must not be taken.
    drive_in(BMU_PDEP, 32'h0000_0001, 32'hFFFF_FFFF, cfg_one(0, 16'hFFFF));
    bus.in_valid = 1'b1;
    flush        = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    check("flush_iv_not_accepted", bus.in_ready, 1'b1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("flush_iv_novld%0d", k), bus.out_valid, 1'b0);
      @(posedge clk); #1;
    end

    // Asynchronous reset mid-RUN.
    start_op(BMU_PEXT, 32'hFFFF_FFFF, 32'h0000_00F0, decode(32'h0000_00F0));
    @(posedge clk); #1;
    check("rst_run_pre", bus.in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_run_async", {bus.in_ready, bus.out_valid, bus.out_data}, {1'b1, 1'b0, 32'h0});
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset while a result is held: out_data must clear too.
    bus.out_ready = 1'b0;
    start_op(BMU_PDEP, 32'h0000_000F, 32'h0000_00F0, decode(32'h0000_00F0));
    wait_valid(lat);
    check("rst_done_pre", {bus.out_valid, bus.out_data}, {1'b1, 32'h0000_00F0});
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_done_async", {bus.in_ready, bus.out_valid, bus.out_data}, {1'b1, 1'b0, 32'h0});
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    run_op(BMU_PEXT, 32'hFFFF_FFFF, 32'h8000_0001, decode(32'h8000_0001), res, lat);
    check("rst_next_op", {lat, res}, {32'd5, 32'h0000_0003});

    // Random operands against the arithmetic pext/pdep model.
    for (int n = 0; n < 2000; n++) begin
      mask = $urandom;
      case (n % 4)
        1: mask = mask & $urandom;
        2: mask = mask | $urandom;
        3: mask = mask & $urandom & $urandom;
        default: ;
      endcase
      if (n == 0) mask = 32'h0;
      if (n == 1) mask = 32'hFFFF_FFFF;
      data = $urandom;
      op   = ($urandom_range(1) == 1) ? BMU_PDEP : BMU_PEXT;
      exp  = (op == BMU_PEXT) ? pext_ref(data, mask) : pdep_ref(data, mask);
      run_op(op, data, mask, decode(mask), res, lat);
      check($sformatf("rand%0d_op%0d_m%08h_d%08h", n, op, mask, data), {lat, res}, {32'd5, exp});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
